fib_trace_capture: RTL and testbench
====================================

// Module: fib_trace_capture
// PURPOSE
//  Downstream of the fib arithmetic core (top: selector -> i, j, x, y).
//  Samples the core's {i,j,x,y} tuple each cycle, fires on a trigger match on i,
//  and captures up to CAP_LIMIT distinct tuples into a FIFO.
//  The FIFO is drained through a valid/ready port to the property-mining trace dumper.
//  Change-detect filter: consecutive identical tuples are stored once.
// PARAMETERS
//  W          11  width of each of i, j, x, y
//  DEPTH      16  FIFO entries, power of two
//  CAP_LIMIT  64  tuples accepted into FIFO per trigger; 1..2^CNT_W-1
//  CNT_W       8  width of sample/drop counters
// PORTS
//  clk        in   1     clock; all logic on rising edge
//  rst        in   1     async, active-low reset
//  in_valid   in   1     core tuple valid this cycle
//  in_i       in   W     core i
//  in_j       in   W     core j
//  in_x       in   W     core x
//  in_y       in   W     core y
//  arm        in   1     pulse: IDLE/DONE -> ARMED
//  trig_val   in   W     trigger compare value for in_i
//  out_valid  out  1     FIFO head valid
//  out_ready  in   1     consumer accepts head
//  out_data   out  4*W   {i,j,x,y}, i in MSBs
//  state      out  2     0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//  cap_cnt    out  CNT_W tuples accepted since last arm
//  drop_cnt   out  CNT_W tuples lost to FIFO full; saturates at all-ones
// BEHAVIOUR
//  Reset (rst==0, async):
//   - state=IDLE; FIFO empty; out_valid=0; out_data=0; cap_cnt=0; drop_cnt=0; prev_valid=0.
//  FSM transitions:
//   - IDLE --arm--> ARMED.
//   - ARMED --(in_valid && in_i==trig_val)--> CAPTURE; the triggering tuple is itself a capture candidate.
//   - CAPTURE --(cap_cnt reaches CAP_LIMIT)--> DONE.
//   - DONE --arm--> ARMED.
//   - arm in ARMED or CAPTURE is ignored.
//   - On arm: cap_cnt=0, drop_cnt=0, prev_valid=0. FIFO contents are kept.
//  Candidate:
//   - in_valid and (state==CAPTURE, or the trigger cycle).
//   - If prev_valid and tuple == prev tuple: discarded, no count.
//   - Otherwise prev<=tuple, prev_valid<=1, then:
//     - FIFO not full, or full with a pop this cycle: push; cap_cnt++.
//     - Else: drop_cnt++ (saturating). cap_cnt unchanged.
//   - Only pushes count toward CAP_LIMIT.
//  FIFO:
//   - Pop when out_valid && out_ready. out_data is the registered head, stable while out_valid && !out_ready.
//   - Push-to-out_valid latency is 1 cycle when empty.
//   - Simultaneous push and pop when full: both occur, occupancy unchanged.
//   - Simultaneous push and pop when empty: push only; out_valid rises next cycle.
//   - Pointers are log2(DEPTH)+1 bits and wrap naturally; full = MSBs differ and the rest are equal.
//  Draining continues in IDLE/DONE. Capture never overwrites unread entries.
//  cap_cnt freezes at CAP_LIMIT in DONE.
//  Mid-operation reset clears FIFO and counters in any state; no partial output.
// STRUCTURE
//  - Shared package fib_trace_pkg: state encodings (ST_IDLE..ST_DONE), tuple width 4*W,
//    field slice offsets. Reused by the dumper and the bench.
//  - One sub-module fib_trace_fifo: W_DATA/DEPTH sync FIFO with push/pop/full/empty and registered head.
//  - FSM, change filter and counters live in the parent.
// TESTING
//  1. Reset mid-CAPTURE with 3 entries queued -> out_valid=0, state=0, cap_cnt=0, drop_cnt=0 asynchronously.
//  2. arm, trig_val=5, i sweeps 0..9 with distinct x, out_ready=1
//     -> first out_data has i=5; cap_cnt=5; state=2.
//  3. CAP_LIMIT=4, trigger hit, 10 distinct tuples -> exactly 4 popped; state=3; cap_cnt=4.
//  4. Trigger, then the same tuple held for 6 cycles, then a new one
//     -> 2 entries pushed; duplicates not counted.
//  5. out_ready=0, DEPTH=16, 20 distinct tuples after trigger
//     -> 16 stored; drop_cnt=4; release ready -> 16 pops in order, no gaps.
//  6. FIFO full with push and pop in the same cycle -> occupancy stays 16; no drop; order preserved.

Source files
------------

// File: rtl/fib_trace_pkg.sv
// fib_trace_pkg
//   Shared definitions for the fib trace capture path: FSM state encodings,
//   default tuple field width, packed tuple width and field bit offsets.
//   A packed tuple is {i, j, x, y} with i in the most significant bits.
//   Used by the capture block, the trace dumper and the bench.
package fib_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int W_DEF   = 11;
  localparam int TUPLE_W = 4 * W_DEF;

  // Low bit of each field inside a packed tuple.
  localparam int OFF_I = 3 * W_DEF;
  localparam int OFF_J = 2 * W_DEF;
  localparam int OFF_X = W_DEF;
  localparam int OFF_Y = 0;

endpackage

// File: rtl/fib_trace_capture_if.sv
// fib_trace_capture_if
//   Tuple input from the fib core plus the valid/ready drain port towards
//   the trace dumper.
//   in_valid, in_i, in_j, in_x, in_y : core tuple and its valid
//   out_valid, out_data              : FIFO head ({i,j,x,y}, i in MSBs)
//   out_ready                        : consumer accepts the head
//   modport slave  : the capture block
//   modport master : the core/consumer side driving it
interface fib_trace_capture_if
  import fib_trace_pkg::*;
#(
  parameter int W = W_DEF
) ();

  logic           in_valid;
  logic [W-1:0]   in_i;
  logic [W-1:0]   in_j;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic           out_valid;
  logic           out_ready;
  logic [4*W-1:0] out_data;

  modport master (
    output in_valid, in_i, in_j, in_x, in_y, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_i, in_j, in_x, in_y, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/fib_trace_fifo.sv
// fib_trace_fifo
//   Synchronous FIFO with a registered head.
//   clk, rst         : clock, async active-low reset
//   push, wdata      : write request and data (ignored when full without pop)
//   pop              : consume the head (ignored when head not valid)
//   full             : all DEPTH entries occupied
//   head_valid/data  : registered head; valid one cycle after a push into empty
//   Pointers carry one extra wrap bit; full when the wrap bits differ and the
//   index bits match.
module fib_trace_fifo #(
  parameter int W_DATA = 44,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [W_DATA-1:0] wdata,
  output logic              full,
  output logic              head_valid,
  output logic [W_DATA-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W_DATA-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              head_valid_r;
  logic [W_DATA-1:0] head_data_r;

  logic [AW:0]       wr_next_s;
  logic [AW:0]       rd_next_s;
  logic              full_s;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic [W_DATA-1:0] head_next_s;

  // Pointer arithmetic and the value the head register takes next cycle.
  always_comb begin
    full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_ok_s    = pop && head_valid_r;
    push_ok_s   = push && (!full_s || pop_ok_s);
    rd_next_s   = pop_ok_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    wr_next_s   = push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    head_next_s = {W_DATA{1'b0}};
    if (rd_next_s == wr_next_s) begin
      head_next_s = {W_DATA{1'b0}};
    end else if (push_ok_s && (rd_next_s == wr_ptr_r)) begin
      // The entry being written right now becomes the head: bypass the array.
      head_next_s = wdata;
    end else begin
      head_next_s = mem_r[rd_next_s[AW-1:0]];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  // Pointers and registered head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r     <= {(AW+1){1'b0}};
      rd_ptr_r     <= {(AW+1){1'b0}};
      head_valid_r <= 1'b0;
      head_data_r  <= {W_DATA{1'b0}};
    end else begin
      wr_ptr_r     <= wr_next_s;
      rd_ptr_r     <= rd_next_s;
      head_valid_r <= (rd_next_s != wr_next_s);
      head_data_r  <= head_next_s;
    end
  end

  assign full       = full_s;
  assign head_valid = head_valid_r;
  assign head_data  = head_data_r;

endmodule

// File: rtl/fib_trace_capture.sv
// fib_trace_capture
//   Watches the fib core's {i,j,x,y} tuple, triggers when i matches trig_val,
//   and stores up to CAP_LIMIT distinct consecutive tuples into a FIFO that
//   drains through a valid/ready port.
//   clk, rst  : clock, async active-low reset
//   bus       : tuple input and drain port (slave side)
//   arm       : pulse, IDLE/DONE -> ARMED, clears counters and change filter
//   trig_val  : trigger compare value for i
//   state     : 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   cap_cnt   : tuples pushed since last arm
//   drop_cnt  : tuples lost to a full FIFO since last arm, saturating
module fib_trace_capture
  import fib_trace_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int DEPTH     = 16,
  parameter int CAP_LIMIT = 64,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  fib_trace_capture_if.slave bus,
  input  logic               arm,
  input  logic [W-1:0]       trig_val,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   cap_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int TW = 4 * W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(CAP_LIMIT);

  state_t           state_r;
  logic [CNT_W-1:0] cap_cnt_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic [TW-1:0]    prev_r;
  logic             prev_valid_r;

  logic [TW-1:0]    tuple_s;
  logic             trig_hit_s;
  logic             accept_s;
  logic             pop_s;
  logic             push_s;
  logic             arm_ok_s;
  logic             at_limit_s;
  logic [CNT_W-1:0] cap_inc_s;
  logic             fifo_full_s;
  logic             head_valid_s;

  assign tuple_s = {bus.in_i, bus.in_j, bus.in_x, bus.in_y};

  // Trigger, change filter and push/drop decision for the current tuple.
  always_comb begin
    trig_hit_s = (state_r == ST_ARMED) && bus.in_valid && (bus.in_i == trig_val);
    // Candidate tuple that is not a repeat of the last one seen.
    accept_s   = bus.in_valid && ((state_r == ST_CAPTURE) || trig_hit_s) &&
                 !(prev_valid_r && (tuple_s == prev_r));
    pop_s      = head_valid_s && bus.out_ready;
    // A full FIFO still takes the push when its head leaves the same cycle.
    push_s     = accept_s && (!fifo_full_s || pop_s);
    arm_ok_s   = arm && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    cap_inc_s  = cap_cnt_r + CNT_ONE;
    at_limit_s = push_s && (cap_inc_s == CNT_LIM);
  end

  // Capture FSM, change-filter history and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cap_cnt_r    <= {CNT_W{1'b0}};
      drop_cnt_r   <= {CNT_W{1'b0}};
      prev_r       <= {TW{1'b0}};
      prev_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (arm) state_r <= ST_ARMED;
        end
        ST_ARMED: begin
          // CAP_LIMIT of 1 completes on the triggering tuple itself.
          if (trig_hit_s) state_r <= at_limit_s ? ST_DONE : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (at_limit_s) state_r <= ST_DONE;
        end
        default: state_r <= ST_IDLE;
      endcase

      if (arm_ok_s) begin
        cap_cnt_r    <= {CNT_W{1'b0}};
        drop_cnt_r   <= {CNT_W{1'b0}};
        prev_valid_r <= 1'b0;
      end else if (accept_s) begin
        prev_r       <= tuple_s;
        prev_valid_r <= 1'b1;
        if (push_s) begin
          cap_cnt_r <= cap_inc_s;
        end else if (drop_cnt_r != CNT_MAX) begin
          drop_cnt_r <= drop_cnt_r + CNT_ONE;
        end
      end
    end
  end

  fib_trace_fifo #(
    .W_DATA (TW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .wdata      (tuple_s),
    .full       (fifo_full_s),
    .head_valid (head_valid_s),
    .head_data  (bus.out_data)
  );

  assign bus.out_valid = head_valid_s;
  assign state         = state_r;
  assign cap_cnt       = cap_cnt_r;
  assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_fib_trace_capture.sv
// Bench for fib_trace_capture: two instances (CAP_LIMIT 64 and 4) driven
// from tasks, checked against a queue-based reference model.
module tb_fib_trace_capture;
  import fib_trace_pkg::*;

  localparam int W     = W_DEF;
  localparam int TW    = TUPLE_W;
  localparam int DEPTH = 16;

  typedef logic [TW-1:0] tuple_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fib_trace_capture_if #(.W(W)) bus_a ();
  fib_trace_capture_if #(.W(W)) bus_b ();

  logic         arm_a, arm_b;
  logic [W-1:0] trig_a, trig_b;
  logic [1:0]   state_a, state_b;
  logic [7:0]   cap_a, drop_a, cap_b, drop_b;

  fib_trace_capture #(.W(W), .DEPTH(DEPTH), .CAP_LIMIT(64), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .arm(arm_a), .trig_val(trig_a),
    .state(state_a), .cap_cnt(cap_a), .drop_cnt(drop_a)
  );

  fib_trace_capture #(.W(W), .DEPTH(DEPTH), .CAP_LIMIT(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .arm(arm_b), .trig_val(trig_b),
    .state(state_b), .cap_cnt(cap_b), .drop_cnt(drop_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: what the spec says the block holds.
  int     m_state, m_cap, m_drop, m_limit;
  bit     m_pv;
  tuple_t m_prev;
  tuple_t m_q[$];     // entries held in the FIFO
  tuple_t exp_q[$];   // entries the consumer should have received
  tuple_t got_q[$];   // entries the consumer did receive

  function automatic tuple_t mk(int i, int j, int x, int y);
    return {W'(i), W'(j), W'(x), W'(y)};
  endfunction

  task automatic idle_inputs();
    bus_a.in_valid = 1'b0; bus_a.in_i = '0; bus_a.in_j = '0; bus_a.in_x = '0; bus_a.in_y = '0;
    bus_a.out_ready = 1'b0; arm_a = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_i = '0; bus_b.in_j = '0; bus_b.in_x = '0; bus_b.in_y = '0;
    bus_b.out_ready = 1'b0; arm_b = 1'b0;
  endtask

  task automatic model_reset(int limit);
    m_state = 0; m_cap = 0; m_drop = 0; m_pv = 1'b0; m_prev = '0; m_limit = limit;
    m_q.delete(); exp_q.delete(); got_q.delete();
  endtask

  task automatic model_step(bit v, tuple_t t, bit a, bit r, logic [W-1:0] trig);
    bit hit;
    if (r && m_q.size() > 0) exp_q.push_back(m_q.pop_front());
    hit = (m_state == 1) && v && (t[TW-1 -: W] == trig);
    if (a && (m_state == 0 || m_state == 3)) begin
      m_state = 1; m_cap = 0; m_drop = 0; m_pv = 1'b0;
    end else if (v && (m_state == 2 || hit)) begin
      if (hit) m_state = 2;
      if (!(m_pv && t == m_prev)) begin
        m_prev = t; m_pv = 1'b1;
        if (m_q.size() < DEPTH) begin
          m_q.push_back(t);
          m_cap++;
          if (m_cap == m_limit) m_state = 3;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  endtask

  // One clock of stimulus on instance sel (0 = dut_a, 1 = dut_b).
  task automatic tick(int sel, bit v, tuple_t t, bit a, bit r);
    @(negedge clk);
    if (sel == 0) begin
      bus_a.in_valid = v; {bus_a.in_i, bus_a.in_j, bus_a.in_x, bus_a.in_y} = t;
      bus_a.out_ready = r; arm_a = a;
      if (bus_a.out_valid && r) got_q.push_back(bus_a.out_data);
      model_step(v, t, a, r, trig_a);
    end else begin
      bus_b.in_valid = v; {bus_b.in_i, bus_b.in_j, bus_b.in_x, bus_b.in_y} = t;
      bus_b.out_ready = r; arm_b = a;
      if (bus_b.out_valid && r) got_q.push_back(bus_b.out_data);
      model_step(v, t, a, r, trig_b);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset(int limit);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset(limit);
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus_a.out_valid); end
    total++; if (bus_a.out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", bus_a.out_data); end
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_a); end
    total++; if (cap_a !== 8'd0) begin bad++; $display("FAIL reset_cap got=%0d exp=0", cap_a); end
    total++; if (drop_a !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_a); end
    rst = 1'b1;
    model_reset(64);
    trig_a = 11'd9;
    tick(0, 1'b0, '0, 1'b1, 1'b0);
    tick(0, 1'b1, mk(9, 1, 1, 1), 1'b0, 1'b0);
    tick(0, 1'b1, mk(9, 1, 2, 1), 1'b0, 1'b0);
    tick(0, 1'b1, mk(2, 1, 3, 1), 1'b0, 1'b0);
    @(negedge clk);
    total++; if (state_a !== 2'(m_state)) begin bad++; $display("FAIL midcap_state got=%0d exp=%0d", state_a, m_state); end
    total++; if (cap_a !== 8'(m_cap)) begin bad++; $display("FAIL midcap_cap got=%0d exp=%0d", cap_a, m_cap); end
    total++; if (bus_a.out_valid !== 1'b1) begin bad++; $display("FAIL midcap_out_valid got=%0b exp=1", bus_a.out_valid); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL async_out_valid got=%0b exp=0", bus_a.out_valid); end
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL async_state got=%0d exp=0", state_a); end
    total++; if (cap_a !== 8'd0) begin bad++; $display("FAIL async_cap got=%0d exp=0", cap_a); end
    total++; if (drop_a !== 8'd0) begin bad++; $display("FAIL async_drop got=%0d exp=0", drop_a); end
    @(negedge clk);
    rst = 1'b1;
    model_reset(64);
  endtask

  task automatic test_trigger_sweep();
    do_reset(64);
    trig_a = 11'd5;
    tick(0, 1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) tick(0, 1'b1, mk(k, $urandom, 100 + k, $urandom), 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) tick(0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sweep_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL sweep_data[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
    if (got_q.size() > 0) begin
      total++; if (got_q[0][OFF_I +: W] !== 11'd5) begin bad++; $display("FAIL sweep_first_i got=%0d exp=5", got_q[0][OFF_I +: W]); end
    end
    total++; if (cap_a !== 8'd5) begin bad++; $display("FAIL sweep_cap got=%0d exp=5", cap_a); end
    total++; if (state_a !== 2'd2) begin bad++; $display("FAIL sweep_state got=%0d exp=2", state_a); end
  endtask

  task automatic test_cap_limit();
    do_reset(4);
    trig_b = 11'd7;
    tick(1, 1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) tick(1, 1'b1, mk(7 + k, $urandom, 200 + k, k), 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) tick(1, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL limit_count got=%0d exp=4", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL limit_data[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
    total++; if (state_b !== 2'd3) begin bad++; $display("FAIL limit_state got=%0d exp=3", state_b); end
    total++; if (cap_b !== 8'd4) begin bad++; $display("FAIL limit_cap got=%0d exp=4", cap_b); end
    total++; if (drop_b !== 8'd0) begin bad++; $display("FAIL limit_drop got=%0d exp=0", drop_b); end
  endtask

  task automatic test_dedup();
    tuple_t t0, t1;
    do_reset(64);
    trig_a = 11'd3;
    t0 = mk(3, $urandom, $urandom, $urandom);
    t1 = t0 ^ tuple_t'(1);
    tick(0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) tick(0, 1'b1, t0, 1'b0, 1'b0);
    tick(0, 1'b1, t1, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (cap_a !== 8'd2) begin bad++; $display("FAIL dedup_cap got=%0d exp=2", cap_a); end
    total++; if (drop_a !== 8'd0) begin bad++; $display("FAIL dedup_drop got=%0d exp=0", drop_a); end
    for (int k = 0; k < 4; k++) tick(0, 1'b0, '0, 1'b0, 1'b1);
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL dedup_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() == 2) begin
      total++; if (got_q[0] !== t0) begin bad++; $display("FAIL dedup_first got=%h exp=%h", got_q[0], t0); end
      total++; if (got_q[1] !== t1) begin bad++; $display("FAIL dedup_second got=%h exp=%h", got_q[1], t1); end
    end
  endtask

  task automatic test_overflow();
    int tv;
    do_reset(64);
    tv = $urandom_range(0, 2047);
    trig_a = W'(tv);
    tick(0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) tick(0, 1'b1, mk((k == 0) ? tv : $urandom, $urandom, k, $urandom), 1'b0, 1'b0);
    @(negedge clk);
    total++; if (cap_a !== 8'd16) begin bad++; $display("FAIL ovf_cap got=%0d exp=16", cap_a); end
    total++; if (drop_a !== 8'd4) begin bad++; $display("FAIL ovf_drop got=%0d exp=4", drop_a); end
    total++; if (state_a !== 2'd2) begin bad++; $display("FAIL ovf_state got=%0d exp=2", state_a); end
    for (int k = 0; k < 16; k++) tick(0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    total++; if (got_q.size() != 16) begin bad++; $display("FAIL ovf_pops got=%0d exp=16", got_q.size()); end
    total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0b exp=0", bus_a.out_valid); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL ovf_data[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_full_push_pop();
    do_reset(64);
    trig_a = 11'd100;
    tick(0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) tick(0, 1'b1, mk(100, k, $urandom, 7), 1'b0, 1'b0);
    tick(0, 1'b1, mk(100, 99, 1, 7), 1'b0, 1'b1);
    @(negedge clk);
    total++; if (cap_a !== 8'd17) begin bad++; $display("FAIL pp_cap got=%0d exp=17", cap_a); end
    total++; if (drop_a !== 8'd0) begin bad++; $display("FAIL pp_drop got=%0d exp=0", drop_a); end
    for (int k = 0; k < 16; k++) tick(0, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    total++; if (bus_a.out_valid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%0b exp=0", bus_a.out_valid); end
    total++; if (got_q.size() != 17) begin bad++; $display("FAIL pp_pops got=%0d exp=17", got_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL pp_data[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random();
    do_reset(64);
    trig_a = W'($urandom_range(0, 3));
    tick(0, 1'b0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 400; c++) begin
      tick(0, $urandom_range(0, 3) != 0,
           mk($urandom_range(0, 3), 0, $urandom_range(0, 2), $urandom_range(0, 1)),
           $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
      total++; if (state_a !== 2'(m_state)) begin bad++; $display("FAIL rnd_state c=%0d got=%0d exp=%0d", c, state_a, m_state); end
      total++; if (cap_a !== 8'(m_cap)) begin bad++; $display("FAIL rnd_cap c=%0d got=%0d exp=%0d", c, cap_a, m_cap); end
      total++; if (drop_a !== 8'(m_drop)) begin bad++; $display("FAIL rnd_drop c=%0d got=%0d exp=%0d", c, drop_a, m_drop); end
    end
    for (int k = 0; k < 20; k++) tick(0, 1'b0, '0, 1'b0, 1'b1);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    trig_a = '0;
    trig_b = '0;
    idle_inputs();
    test_reset();
    test_trigger_sweep();
    test_cap_limit();
    test_dedup();
    test_overflow();
    test_full_push_pop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
